// File: rtl/vblank_bitmap_loader.sv
// Copies one 16-row image from a synchronous ROM into the bitmap RAM write port,
// only at the start of vertical sync. Each image is held for HOLD_FRAMES frames, then the next loads.
module vblank_bitmap_loader #(
  parameter int ROWS        = 16,
  parameter int ROW_W       = 16,
  parameter int NUM_IMG     = 6,
  parameter int ROM_AW      = 7,
  parameter int HOLD_FRAMES = 15
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROW_W-1:0]  rom_data,
  output logic              write_en,
  output logic [3:0]        write_addr,
  output logic [ROW_W-1:0]  write_data,
  output logic [2:0]        img_idx,
  output logic              busy,
  output logic              img_done
);

  localparam int FC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_VS, LOAD, HOLD} state_t;

  state_t          state;
  logic            vs_d;
  logic            vs_fall;
  logic [4:0]      row;
  logic [FC_W-1:0] frame_cnt;
  logic [2:0]      next_idx;

  assign vs_fall  = vs_d & ~vsync_n;
  assign next_idx = (img_idx == 3'(NUM_IMG - 1)) ? 3'd0 : img_idx + 3'd1;

  // NOTE: write_data is the ROM output gated by the registered strobe; registering it would
  // add a second cycle of latency on top of the ROM read and misalign it with write_addr.
  assign write_data = write_en ? rom_data : '0;

  function automatic logic [ROM_AW-1:0] row0_addr(input logic [2:0] idx);
    return ROM_AW'({idx, 4'b0000});
  endfunction

  // NOTE: every register here uses <= so all decisions in a cycle see the pre-edge state.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state      <= IDLE;
      vs_d       <= 1'b1;
      row        <= '0;
      frame_cnt  <= '0;
      rom_addr   <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      img_idx    <= '0;
      busy       <= 1'b0;
      img_done   <= 1'b0;
    end else begin
      vs_d     <= vsync_n;
      img_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!enable) begin
            state <= IDLE;
          end else if (vs_fall) begin
            state    <= LOAD;
            row      <= '0;
            busy     <= 1'b1;
            rom_addr <= row0_addr(img_idx);
          end
        end
        LOAD: begin
          // Row ROWS is the drain cycle: the last ROM word is written, no new address issued.
          if (row == 5'(ROWS)) begin
            write_en  <= 1'b0;
            img_done  <= 1'b1;
            busy      <= 1'b0;
            frame_cnt <= '0;
            state     <= enable ? HOLD : IDLE;
          end else begin
            write_en   <= 1'b1;
            write_addr <= row[3:0];
            row        <= row + 5'd1;
            if (row < 5'(ROWS - 1)) rom_addr <= rom_addr + ROM_AW'(1);
          end
        end
        HOLD: begin
          if (!enable) begin
            state <= IDLE;
          end else if (vs_fall) begin
            if (frame_cnt == FC_W'(HOLD_FRAMES - 1)) begin
              img_idx  <= next_idx;
              state    <= LOAD;
              row      <= '0;
              busy     <= 1'b1;
              rom_addr <= row0_addr(next_idx);
            end else begin
              frame_cnt <= frame_cnt + FC_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/vblank_bitmap_loader.md
Name: vblank_bitmap_loader

Overview:
- Upstream feeder for the 16x16 monochrome bitmap RAM inside vga_interface.
- Steps through NUM_IMG 16-row images held in a synchronous ROM and copies one image (16 rows x 16 bits) into the RAM write port.
- Copies happen only at the start of vertical sync, so the display never tears.
- Each image is held for HOLD_FRAMES frames, then the next image loads; the sequence wraps.

Parameters:
- ROWS, 16, rows per image; also the RAM depth.
- ROW_W, 16, bits per row; also the RAM/ROM data width.
- NUM_IMG, 6, number of images in the ROM.
- ROM_AW, 7, ROM address width; must satisfy NUM_IMG*ROWS <= 2^ROM_AW.
- HOLD_FRAMES, 15, frames each image is displayed (~250 ms at 60 Hz).

Ports:
- vga_clk  in  1  pixel clock; also clocks the ROM and the RAM write port.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  level; 1 = run the image sequence.
- vsync_n  in  1  VSYNC_Sig from vga_interface, active-low; same clock domain.
- rom_addr  out  ROM_AW  ROM read address.
- rom_data  in  ROW_W  ROM data; 1-cycle read latency.
- write_en  out  1  RAM write strobe.
- write_addr  out  4  RAM row address.
- write_data  out  ROW_W  RAM row data.
- img_idx  out  3  index of the image currently loaded or loading.
- busy  out  1  high while in LOAD.
- img_done  out  1  one-cycle pulse after the last row write of an image.

Behaviour:
- Reset values:
  - rom_addr=0, write_en=0, write_addr=0, write_data=0, img_idx=0, busy=0, img_done=0.
  - FSM=IDLE, row counter=0, frame counter=0, vs_d=1.
- vs_fall = vs_d & ~vsync_n, where vs_d is vsync_n registered once. Every FSM edge decision uses vs_fall in the same cycle.
- FSM states: IDLE, WAIT_VS, LOAD, HOLD.
- IDLE: when enable=1, go to WAIT_VS.
- WAIT_VS:
  - enable=0 -> IDLE.
  - On vs_fall -> LOAD; row=0, busy=1.
- LOAD (17 cycles, k=0..16):
  - Cycles k=0..15: rom_addr = {img_idx, 4'b0000} + k, truncated to ROM_AW bits.
  - Cycles k=1..16: write_en=1, write_addr=k-1, write_data=rom_data. This is the 1-cycle ROM latency, pipelined.
  - Cycle 16: no new ROM address is issued.
  - After cycle 16: write_en=0, img_done=1 for one cycle, busy=0, frame counter=0.
  - Then go to HOLD if enable=1, otherwise IDLE.
  - enable is ignored while in LOAD; a started image always completes, so the RAM never holds a partial image.
  - vs_fall during LOAD is ignored.
- HOLD:
  - enable=0 -> IDLE immediately; img_idx is kept.
  - On vs_fall with frame counter == HOLD_FRAMES-1:
    - img_idx <= (img_idx == NUM_IMG-1) ? 0 : img_idx+1.
    - Go to LOAD in the next cycle; the new image loads in that same vertical sync period.
  - On vs_fall otherwise: frame counter +1.
- Re-enable from IDLE goes through WAIT_VS and reloads the current img_idx (no advance).
- rst=1 in any state, including mid-LOAD, returns every output and counter to its reset value on the next edge. The RAM may then hold a partially written image; the next load overwrites all 16 rows.
- Timing margin: LOAD takes 17 clocks, far inside the vertical blanking interval.
- Widths:
  - Frame counter: clog2(HOLD_FRAMES) bits.
  - Row counter: 5 bits, so that value 16 (the drain cycle) is representable.

Test Plan:
- Reset then enable=1, ROM word = address: on the first vs_fall, 16 writes with write_addr 0..15 and write_data 0..15, starting 2 cycles after vs_fall; img_done pulses once, 1 cycle after the last write; busy is high for 17 cycles.
- Hold timing: count vs_fall events after the first load; the second load starts on the 15th vs_fall and writes data 16..31, with img_idx=1.
- Wrap-around: run 6 images; after img_idx=5 (data 80..95), the next load has img_idx=0 and writes data 0..15.
- Drop enable at LOAD row 5: all 16 writes still complete, img_done pulses, FSM goes to IDLE; re-enabling reloads the same img_idx on the next vs_fall.
- rst=1 at LOAD row 8: the next cycle has write_en=0, img_idx=0, busy=0; with enable held high, the next vs_fall reloads image 0 completely.
- vsync_n held low for many cycles: only one LOAD per falling edge; a low level alone never retriggers.
